// File: rtl/wb_cmd_master_pkg.sv
// Shared types for the Wishbone command master: command/response tags, FSM states
// and the bit position of the auto-increment flag inside a special command.
package wb_cmd_pkg;

  typedef enum logic [1:0] {
    CMD_RD   = 2'd0,
    CMD_WR   = 2'd1,
    CMD_ADDR = 2'd2,
    CMD_SPEC = 2'd3
  } cmd_e;

  typedef enum logic [1:0] {
    RSP_RD  = 2'd0,
    RSP_WR  = 2'd1,
    RSP_CFG = 2'd2,
    RSP_ERR = 2'd3
  } rsp_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RSP  = 2'd2
  } state_e;

  localparam int unsigned SPEC_AUTOINC_BIT = 0;

endpackage

// File: rtl/wb_cmd_master_if.sv
// Command stream, response stream and Wishbone B4 classic bus of wb_cmd_master.
// The master modport is the block's view; slave is the view of whatever surrounds it.
interface wb_cmd_master_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic [DW+1:0]   in_cmd_word;
  logic            in_cmd_valid;
  logic            in_cmd_ready;
  logic [DW+1:0]   out_rsp_word;
  logic            out_rsp_valid;
  logic            out_rsp_ready;
  logic            o_wb_cyc;
  logic            o_wb_stb;
  logic            o_wb_we;
  logic [AW-1:0]   o_wb_addr;
  logic [DW/8-1:0] o_wb_sel;
  logic [DW-1:0]   o_wb_data;
  logic [DW-1:0]   i_wb_data;
  logic            i_wb_ack;
  logic            i_wb_err;

  modport master (
    input  in_cmd_word, in_cmd_valid, out_rsp_ready, i_wb_data, i_wb_ack, i_wb_err,
    output in_cmd_ready, out_rsp_word, out_rsp_valid,
    output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_sel, o_wb_data
  );

  modport slave (
    output in_cmd_word, in_cmd_valid, out_rsp_ready, i_wb_data, i_wb_ack, i_wb_err,
    input  in_cmd_ready, out_rsp_word, out_rsp_valid,
    input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_sel, o_wb_data
  );
endinterface

// File: rtl/wb_cmd_master.sv
// Wishbone B4 classic master executing one tagged command at a time, one response per command.
// Optional ack timeout enabled by defining WB_CMD_MASTER_TIMEOUT_EN.
module wb_cmd_master
  import wb_cmd_pkg::*;
#(
  parameter int unsigned AW     = 32,
  parameter int unsigned DW     = 32,
  parameter int unsigned TO_CYC = 255
) (
  input logic              clk,
  input logic              rst,
  wb_cmd_master_if.master  bus
);

  state_e          state_q, state_d;
  cmd_e            cmd_q, cmd_d;
  logic [DW-1:0]   pay_q, pay_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            autoinc_q, autoinc_d;
  logic [DW+1:0]   rsp_q, rsp_d;
  logic [DW-1:0]   addr_as_data;
  logic [AW-1:0]   word_as_addr;

  // Width adaptation between address and data domains (zero-extend or truncate).
  if (AW >= DW) begin : g_wide_addr
    assign addr_as_data = addr_q[DW-1:0];
    assign word_as_addr = {{(AW-DW){1'b0}}, bus.in_cmd_word[DW-1:0]};
  end else begin : g_narrow_addr
    assign addr_as_data = {{(DW-AW){1'b0}}, addr_q};
    assign word_as_addr = bus.in_cmd_word[AW-1:0];
  end

`ifdef WB_CMD_MASTER_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TO_CYC + 1);
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  assign bus.in_cmd_ready  = (state_q == IDLE) && !rst;
  assign bus.o_wb_cyc      = (state_q == BUS);
  assign bus.o_wb_stb      = (state_q == BUS);
  assign bus.o_wb_we       = (state_q == BUS) && (cmd_q == CMD_WR);
  assign bus.o_wb_sel      = {(DW/8){state_q == BUS}};
  assign bus.o_wb_addr     = addr_q;
  assign bus.o_wb_data     = pay_q;
  assign bus.out_rsp_valid = (state_q == RSP);
  assign bus.out_rsp_word  = rsp_q;

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    pay_d     = pay_q;
    addr_d    = addr_q;
    autoinc_d = autoinc_q;
    rsp_d     = rsp_q;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.in_cmd_valid && bus.in_cmd_ready) begin
          cmd_d = cmd_e'(bus.in_cmd_word[DW+1:DW]);
          pay_d = bus.in_cmd_word[DW-1:0];
          unique case (cmd_e'(bus.in_cmd_word[DW+1:DW]))
            CMD_RD, CMD_WR: begin
              state_d = BUS;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
              cnt_d   = '0;
`endif
            end
            CMD_ADDR: begin
              addr_d  = word_as_addr;
              rsp_d   = {RSP_CFG, bus.in_cmd_word[DW-1:0]};
              state_d = RSP;
            end
            default: begin
              autoinc_d = bus.in_cmd_word[SPEC_AUTOINC_BIT];
              rsp_d     = {RSP_CFG, bus.in_cmd_word[DW-1:0]};
              state_d   = RSP;
            end
          endcase
        end
      end
      BUS: begin
        // err wins over a simultaneous ack; a terminating slave wins over the timeout.
        if (bus.i_wb_err) begin
          rsp_d   = {RSP_ERR, addr_as_data};
          state_d = RSP;
        end else if (bus.i_wb_ack) begin
          rsp_d = (cmd_q == CMD_WR) ? {RSP_WR, pay_q} : {RSP_RD, bus.i_wb_data};
          if (autoinc_q) begin
            addr_d = addr_q + AW'(DW / 8);
          end
          state_d = RSP;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
        end else if (cnt_q == CW'(TO_CYC - 1)) begin
          rsp_d   = {RSP_ERR, addr_as_data};
          state_d = RSP;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      RSP: begin
        if (bus.out_rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cmd_q     <= CMD_RD;
      pay_q     <= '0;
      addr_q    <= '0;
      autoinc_q <= 1'b0;
      rsp_q     <= '0;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      pay_q     <= pay_d;
      addr_q    <= addr_d;
      autoinc_q <= autoinc_d;
      rsp_q     <= rsp_d;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master: drives on the falling edge, checks on the falling edge.
module tb_wb_cmd_master;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  wb_cmd_master_if #(.AW(AW), .DW(DW)) bus ();

  wb_cmd_master #(.AW(AW), .DW(DW), .TO_CYC(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a command and return at the falling edge after the accepting edge.
  task automatic send_cmd(input logic [1:0] cmd, input logic [31:0] pay);
    int guard = 0;
    bus.in_cmd_word  = {cmd, pay};
    bus.in_cmd_valid = 1'b1;
    while (!bus.in_cmd_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("cmd_ready", {63'd0, bus.in_cmd_ready}, 64'd1);
    @(negedge clk);
    bus.in_cmd_valid = 1'b0;
  endtask

  // Slave terminates after n cycles of cyc; returns at the falling edge after termination.
  task automatic wb_reply(input int n, input logic [31:0] data, input logic ack, input logic err);
    repeat (n - 1) @(negedge clk);
    bus.i_wb_data = data;
    bus.i_wb_ack  = ack;
    bus.i_wb_err  = err;
    @(negedge clk);
    bus.i_wb_ack  = 1'b0;
    bus.i_wb_err  = 1'b0;
    chk("cyc_drop", {63'd0, bus.o_wb_cyc}, 64'd0);
  endtask

  task automatic get_rsp(input string tag, input logic [1:0] tg, input logic [31:0] pay);
    chk({tag, "_valid"}, {63'd0, bus.out_rsp_valid}, 64'd1);
    chk({tag, "_word"}, {30'd0, bus.out_rsp_word}, {30'd0, tg, pay});
    bus.out_rsp_ready = 1'b1;
    @(negedge clk);
    bus.out_rsp_ready = 1'b0;
    chk({tag, "_idle"}, {63'd0, bus.in_cmd_ready}, 64'd1);
  endtask

  initial begin
    int cnt;
    bus.in_cmd_word   = '0;
    bus.in_cmd_valid  = 1'b0;
    bus.out_rsp_ready = 1'b0;
    bus.i_wb_data     = '0;
    bus.i_wb_ack      = 1'b0;
    bus.i_wb_err      = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cyc", {63'd0, bus.o_wb_cyc}, 64'd0);
    chk("rst_stb", {63'd0, bus.o_wb_stb}, 64'd0);
    chk("rst_rspv", {63'd0, bus.out_rsp_valid}, 64'd0);
    chk("rst_addr", {32'd0, bus.o_wb_addr}, 64'd0);
    chk("rst_sel", {60'd0, bus.o_wb_sel}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {63'd0, bus.in_cmd_ready}, 64'd1);

    // 1: set address then write, slave acks after 3 cycles
    send_cmd(2'd2, 32'h100);
    chk("t1_addr_set", {32'd0, bus.o_wb_addr}, 64'h100);
    get_rsp("t1_addr", 2'd2, 32'h100);
    send_cmd(2'd1, 32'hDEADBEEF);
    chk("t1_cyc", {62'd0, bus.o_wb_cyc, bus.o_wb_stb}, 64'd3);
    chk("t1_we", {63'd0, bus.o_wb_we}, 64'd1);
    chk("t1_sel", {60'd0, bus.o_wb_sel}, 64'hF);
    chk("t1_wdata", {32'd0, bus.o_wb_data}, 64'hDEADBEEF);
    chk("t1_waddr", {32'd0, bus.o_wb_addr}, 64'h100);
    wb_reply(3, 32'h0, 1'b1, 1'b0);
    get_rsp("t1_wr", 2'd1, 32'hDEADBEEF);
    chk("t1_addr_kept", {32'd0, bus.o_wb_addr}, 64'h100);

    // 2: auto-increment across the address wrap
    send_cmd(2'd3, 32'h1);
    get_rsp("t2_spec", 2'd2, 32'h1);
    send_cmd(2'd2, 32'hFFFFFFFC);
    get_rsp("t2_addr", 2'd2, 32'hFFFFFFFC);
    send_cmd(2'd0, 32'h0);
    chk("t2_raddr0", {32'd0, bus.o_wb_addr}, 64'hFFFFFFFC);
    chk("t2_we", {63'd0, bus.o_wb_we}, 64'd0);
    wb_reply(1, 32'h11, 1'b1, 1'b0);
    get_rsp("t2_rd0", 2'd0, 32'h11);
    send_cmd(2'd0, 32'h0);
    chk("t2_raddr1", {32'd0, bus.o_wb_addr}, 64'h0);
    wb_reply(2, 32'h22, 1'b1, 1'b0);
    get_rsp("t2_rd1", 2'd0, 32'h22);
    chk("t2_addr_after", {32'd0, bus.o_wb_addr}, 64'h4);

    // 3: ack and err together count as an error; no increment
    send_cmd(2'd0, 32'h0);
    wb_reply(2, 32'h33, 1'b1, 1'b1);
    get_rsp("t3_err", 2'd3, 32'h4);
    chk("t3_addr_kept", {32'd0, bus.o_wb_addr}, 64'h4);

    // 4: response back-pressure; stray ack outside BUS is ignored
    send_cmd(2'd3, 32'h0);
    get_rsp("t4_spec", 2'd2, 32'h0);
    send_cmd(2'd1, 32'h55);
    wb_reply(1, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      bus.i_wb_ack = (i == 5);
      chk("t4_hold_valid", {63'd0, bus.out_rsp_valid}, 64'd1);
      chk("t4_hold_word", {30'd0, bus.out_rsp_word}, {30'd0, 2'd1, 32'h55});
      chk("t4_hold_ready", {63'd0, bus.in_cmd_ready}, 64'd0);
      @(negedge clk);
    end
    bus.i_wb_ack = 1'b0;
    chk("t4_cyc_idle", {63'd0, bus.o_wb_cyc}, 64'd0);
    get_rsp("t4_wr", 2'd1, 32'h55);
    chk("t4_addr_kept", {32'd0, bus.o_wb_addr}, 64'h4);

    // 5: silent slave
    send_cmd(2'd0, 32'h0);
`ifdef WB_CMD_MASTER_TIMEOUT_EN
    cnt = 0;
    while (bus.o_wb_cyc && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
    chk("t5_cyc_len", 64'(cnt), 64'd8);
    get_rsp("t5_timeout", 2'd3, 32'h4);
`else
    cnt = 0;
    while (bus.o_wb_cyc && cnt < 30) begin
      cnt++;
      @(negedge clk);
    end
    chk("t5_cyc_len", 64'(cnt), 64'd30);
    wb_reply(1, 32'h77, 1'b1, 1'b0);
    get_rsp("t5_late_ack", 2'd0, 32'h77);
`endif
    chk("t5_addr_kept", {32'd0, bus.o_wb_addr}, 64'h4);

    // 6: reset during BUS
    send_cmd(2'd3, 32'h1);
    get_rsp("t6_spec", 2'd2, 32'h1);
    send_cmd(2'd2, 32'h200);
    get_rsp("t6_addr", 2'd2, 32'h200);
    send_cmd(2'd0, 32'h0);
    chk("t6_cyc_pre", {63'd0, bus.o_wb_cyc}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_cyc", {62'd0, bus.o_wb_cyc, bus.o_wb_stb}, 64'd0);
    chk("t6_rspv", {63'd0, bus.out_rsp_valid}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_ready", {63'd0, bus.in_cmd_ready}, 64'd1);
    chk("t6_addr0", {32'd0, bus.o_wb_addr}, 64'h0);
    send_cmd(2'd0, 32'h0);
    wb_reply(1, 32'h99, 1'b1, 1'b0);
    get_rsp("t6_rd", 2'd0, 32'h99);
    chk("t6_autoinc_off", {32'd0, bus.o_wb_addr}, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
